bilbo_bist_ctrl: RTL
====================

# bilbo_bist_ctrl

Sequencer for a BILBO-based self-test pair: one BILBO register acting as test pattern generator (TPG) ahead of the circuit under test, one acting as signature analyser (MISR) behind it. On `Start` it does the following, then returns both BILBOs to normal mode:

- scan-loads a seed into the TPG and clears the MISR;
- runs a fixed number of PRPG/MISR cycles;
- scans the signature out of the MISR;
- compares it with a golden value.

## Interface

Parameters:

- `NBITS`, 4: width of both BILBO registers, ≥2.
- `NPATTERNS`, 16: number of test cycles in RUN, ≥1.
- `SEED`, 4'b1011: `[1:NBITS]` value loaded into the TPG. Bit numbering matches BILBO `Q[1:NBITS]`. Must be non-zero; zero locks the PRPG.
- `GOLDEN`, 4'b0000: expected MISR signature, `[1:NBITS]` numbering.

Ports:

- `Clk`, in, 1: single clock, rising edge.
- `Rst`, in, 1: synchronous, active-high reset.
- `Start`, in, 1: begin a test. Sampled only in IDLE.
- `Abort`, in, 1: synchronous abandon of a running test.
- `Busy`, out, 1: test in progress.
- `Done`, out, 1: level; a test has finished since the last `Start`/`Rst`.
- `Pass`, out, 1: valid when `Done`=1; signature matched `GOLDEN`.
- `Signature`, out, `[1:NBITS]`: last unloaded MISR contents.
- `TpgB1`, `TpgB2`, `TpgCE`, `TpgSi`, out, 1 each: TPG BILBO controls.
- `MisrB1`, `MisrB2`, `MisrCE`, `MisrSi`, out, 1 each: MISR BILBO controls.
- `MisrSo`, in, 1: MISR BILBO serial out, equal to its `Q[NBITS]`.

## Operation

- All outputs are registered and are a function of the state plus the counter (Moore-style).
- BILBO mode encoding `{B1,B2}`: 00 shift, 01 PRPG, 10 normal, 11 MISR.
- One down-counter, width `$clog2(max(NBITS, NPATTERNS))+1`, is loaded on each state entry.

States:

- **IDLE**
  - Both BILBOs: mode 10, CE=0. `TpgSi`=`MisrSi`=0, `Busy`=0.
  - `Start`=1 → INIT. On that transition `Done` and `Pass` clear.
- **INIT**, NBITS cycles
  - Both BILBOs: mode 00, CE=1.
  - `TpgSi` presents `SEED[NBITS]`, `SEED[NBITS-1]`, …, `SEED[1]`, one bit per cycle. After INIT the TPG `Q` equals `SEED`.
  - `MisrSi`=0, so the MISR is cleared.
  - → RUN.
- **RUN**, NPATTERNS cycles
  - TPG: mode 01, CE=1. MISR: mode 11, CE=1.
  - → UNLOAD.
- **UNLOAD**, NBITS cycles
  - TPG: CE=0, mode 10. MISR: mode 00, CE=1, `MisrSi`=0.
  - Each cycle samples `MisrSo` at the same edge that shifts the MISR.
  - The k-th sample (k=1..NBITS) is stored as `Signature[NBITS-k+1]`. The first sample is the final MISR `Q[NBITS]`.
  - → CMP.
- **CMP**, 1 cycle
  - Both BILBOs: CE=0.
  - `Pass` ← (`Signature` == `GOLDEN`), `Done` ← 1.
  - → IDLE.

Boundary rules:

- `Start` while `Busy`=1: ignored.
- `Start` held high: a new test begins on the first IDLE cycle after CMP. `Done` is then visible for one cycle only.
- `Abort`=1 in INIT/RUN/UNLOAD/CMP: next state is IDLE with `Done`=1, `Pass`=0. `Signature` keeps whatever was captured.
- `Abort` in IDLE: no effect.
- `Abort` and `Rst` together: `Rst` wins.
- `Rst`=1 at any edge forces:
  - state IDLE, counter 0;
  - `Busy`=`Done`=`Pass`=0, `Signature`=0;
  - `TpgB1`=`MisrB1`=1, `TpgB2`=`MisrB2`=0, both CE=0, both Si=0.
- `Rst` mid-test leaves the BILBO contents undefined. A new `Start` fully re-initialises them.

## Timing

- `Start` sampled at edge t0 (IDLE) → `Busy`=1 and first INIT outputs valid from t0 until edge t0+1.
- Busy duration is 2·NBITS+NPATTERNS+1 cycles. `Done`/`Pass` are valid from the edge ending CMP.
- Default parameters: 25 Busy cycles.
- Control outputs are stable for the whole cycle before the edge at which the BILBO acts.
- The circuit under test is combinational between TPG `Q` and MISR `Z`. There is no flush cycle.
- Latency `Start` → `Done`: 2·NBITS+NPATTERNS+1 edges.

## Test plan

- **Reset values:** `Rst`=1 for 2 cycles → `Busy`/`Done`/`Pass`=0, `Signature`=0, both modes 10, both CE=0.
- **Seed load:** NBITS=4, SEED=4'b1011, `Start` pulse → `TpgSi` sequence 1,1,0,1 on INIT cycles 1-4 with mode 00. Real BILBO TPG `Q`=1011 at RUN entry.
- **Cycle count and unload:** NPATTERNS=8, `MisrSo` tied 1, GOLDEN=0000 → `Busy` high exactly 17 cycles, 8 of them RUN with modes 01/11. `Signature`=1111, `Done`=1, `Pass`=0.
- **Pass case:** `MisrSo` driven 1,0,0,1 during UNLOAD cycles 1-4, GOLDEN=4'b1001 → `Signature`=1001 (`Signature[4]`=1 first), `Pass`=1.
- **Abort:** `Abort`=1 in RUN cycle 3 → next cycle IDLE, `Busy`=0, `Done`=1, `Pass`=0, both CE=0. A following `Start` runs a full test.
- **Edge cases:**
  - `Start` pulsed again mid-RUN → no effect on the cycle count.
  - `Rst` asserted in UNLOAD → all reset values next cycle.
  - `Start`+`Rst` together → stays IDLE.

Source files
------------

// File: rtl/bilbo_bist_ctrl.sv
// BILBO self-test sequencer: seeds the TPG, clears the MISR,
// runs the patterns, unloads the signature and compares it.
module bilbo_bist_ctrl #(
  parameter int             NBITS     = 4,
  parameter int             NPATTERNS = 16,
  parameter logic [1:NBITS] SEED      = 4'b1011,
  parameter logic [1:NBITS] GOLDEN    = 4'b0000
) (
  input  logic           Clk,
  input  logic           Rst,
  input  logic           Start,
  input  logic           Abort,
  output logic           Busy,
  output logic           Done,
  output logic           Pass,
  output logic [1:NBITS] Signature,
  output logic           TpgB1,
  output logic           TpgB2,
  output logic           TpgCE,
  output logic           TpgSi,
  output logic           MisrB1,
  output logic           MisrB2,
  output logic           MisrCE,
  output logic           MisrSi,
  input  logic           MisrSo
);

  localparam int MAXC = (NBITS > NPATTERNS) ? NBITS : NPATTERNS;
  localparam int CW   = $clog2(MAXC) + 1;

  localparam logic [CW-1:0] LD_BITS = CW'(NBITS - 1);
  localparam logic [CW-1:0] LD_PAT  = CW'(NPATTERNS - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_INIT   = 3'd1;
  localparam logic [2:0] S_RUN    = 3'd2;
  localparam logic [2:0] S_UNLOAD = 3'd3;
  localparam logic [2:0] S_CMP    = 3'd4;

  localparam logic [1:0] M_SHIFT  = 2'b00;
  localparam logic [1:0] M_PRPG   = 2'b01;
  localparam logic [1:0] M_NORMAL = 2'b10;
  localparam logic [1:0] M_MISR   = 2'b11;

  logic [2:0]    state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic          last;

  logic [1:0] tpg_m, misr_m;
  logic       tpg_ce, misr_ce, tpg_si;

  assign last = (cnt == '0);

  // Next state and counter; each state reloads the counter on entry
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    unique case (state)
      S_IDLE: begin
        if (Start) begin
          state_d = S_INIT;
          cnt_d   = LD_BITS;
        end
      end
      S_INIT: begin
        if (last) begin
          state_d = S_RUN;
          cnt_d   = LD_PAT;
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end
      S_RUN: begin
        if (last) begin
          state_d = S_UNLOAD;
          cnt_d   = LD_BITS;
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end
      S_UNLOAD: begin
        if (last) begin
          state_d = S_CMP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    if (Abort && state != S_IDLE) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end
  end

  // BILBO controls decoded from the upcoming state so they register
  // in time for the cycle in which that state is active
  always_comb begin
    tpg_m   = M_NORMAL;
    misr_m  = M_NORMAL;
    tpg_ce  = 1'b0;
    misr_ce = 1'b0;
    tpg_si  = 1'b0;
    unique case (1'b1)
      (state_d == S_INIT): begin
        tpg_m   = M_SHIFT;
        misr_m  = M_SHIFT;
        tpg_ce  = 1'b1;
        misr_ce = 1'b1;
      end
      (state_d == S_RUN): begin
        tpg_m   = M_PRPG;
        misr_m  = M_MISR;
        tpg_ce  = 1'b1;
        misr_ce = 1'b1;
      end
      (state_d == S_UNLOAD): begin
        misr_m  = M_SHIFT;
        misr_ce = 1'b1;
      end
      default: ;
    endcase
    for (int i = 1; i <= NBITS; i++) begin
      if (state_d == S_INIT && cnt_d == CW'(i - 1))
        tpg_si = SEED[i];
    end
  end

  // State, registered controls, signature capture and verdict
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      Pass      <= 1'b0;
      Signature <= '0;
      TpgB1     <= 1'b1;
      TpgB2     <= 1'b0;
      TpgCE     <= 1'b0;
      TpgSi     <= 1'b0;
      MisrB1    <= 1'b1;
      MisrB2    <= 1'b0;
      MisrCE    <= 1'b0;
      MisrSi    <= 1'b0;
    end else begin
      state           <= state_d;
      cnt             <= cnt_d;
      Busy            <= (state_d != S_IDLE);
      {TpgB1, TpgB2}  <= tpg_m;
      {MisrB1, MisrB2} <= misr_m;
      TpgCE           <= tpg_ce;
      TpgSi           <= tpg_si;
      MisrCE          <= misr_ce;
      MisrSi          <= 1'b0;
      if (state == S_IDLE && Start) begin
        Done <= 1'b0;
        Pass <= 1'b0;
      end
      if (state != S_IDLE && Abort) begin
        Done <= 1'b1;
        Pass <= 1'b0;
      end else if (state == S_CMP) begin
        Done <= 1'b1;
        Pass <= (Signature == GOLDEN);
      end
      if (state == S_UNLOAD && !Abort) begin
        for (int i = 1; i <= NBITS; i++) begin
          if (cnt == CW'(i - 1))
            Signature[i] <= MisrSo;
        end
      end
    end
  end

endmodule
